// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer for the button-piano note memory: records run-length {dur, note}
// entries while sw1 is high and plays them back on a play pulse. Define LOOP_PLAY_EN for looping playback.
module note_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int NOTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [4:0]        buttons,
  input  logic              sw1,
  input  logic              play,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [NOTE_W+7:0] mem_wdata,
  input  logic [NOTE_W+7:0] mem_rdata,
  output logic [NOTE_W-1:0] current_note,
  output logic              busy,
  output logic              rec_full,
  output logic [ADDR_W:0]   length
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_LEN   = (ADDR_W+1)'(1);

`ifdef LOOP_PLAY_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REC, PLAY_RD, PLAY_LD, PLAY_HOLD} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W:0]    wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [NOTE_W-1:0]  run_code, run_code_nxt;
  logic [7:0]         run_dur, run_dur_nxt;
  logic [7:0]         hold_cnt, hold_cnt_nxt;
  logic [ADDR_W:0]    length_nxt;
  logic               rec_full_nxt;
  logic [NOTE_W-1:0]  current_note_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [NOTE_W+7:0]  mem_wdata_nxt;
  logic               mem_we_nxt;
  logic               sw1_q;
  logic               wr_req;

  logic [2:0]         btn_code;
  logic [NOTE_W-1:0]  live_note;
  logic [7:0]         rec_dur;
  logic [NOTE_W-1:0]  rd_note;
  logic [7:0]         rd_dur;
  logic               abort, play_stop, hold_last, seq_last;

  // Lowest-index pressed button wins; nothing pressed is a rest.
  always_comb begin
    btn_code = 3'd0;
    if      (buttons[0]) btn_code = 3'd1;
    else if (buttons[1]) btn_code = 3'd2;
    else if (buttons[2]) btn_code = 3'd3;
    else if (buttons[3]) btn_code = 3'd4;
    else if (buttons[4]) btn_code = 3'd5;
  end

  assign live_note = NOTE_W'(btn_code);
  assign rec_dur   = run_dur + 8'(tick);
  assign rd_note   = mem_rdata[NOTE_W-1:0];
  assign rd_dur    = mem_rdata[NOTE_W+7:NOTE_W];
  assign abort     = sw1 & ~sw1_q;
  assign play_stop = LOOP_EN & play;
  assign hold_last = (hold_cnt == 8'd1);
  assign seq_last  = ({1'b0, rd_ptr} == (length - ONE_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      run_code     <= '0;
      run_dur      <= '0;
      hold_cnt     <= '0;
      length       <= '0;
      rec_full     <= 1'b0;
      current_note <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      sw1_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      run_code     <= run_code_nxt;
      run_dur      <= run_dur_nxt;
      hold_cnt     <= hold_cnt_nxt;
      length       <= length_nxt;
      rec_full     <= rec_full_nxt;
      current_note <= current_note_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      mem_we       <= mem_we_nxt;
      busy         <= (state_nxt != IDLE);
      sw1_q        <= sw1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sw1)                        state_nxt = REC;
        else if (play && length != '0)  state_nxt = PLAY_RD;
      end
      REC: begin
        if (!sw1) state_nxt = IDLE;
      end
      PLAY_RD, PLAY_LD, PLAY_HOLD: begin
        if (abort || play_stop)    state_nxt = IDLE;
        else if (state == PLAY_RD) state_nxt = PLAY_LD;
        else if (state == PLAY_LD) state_nxt = PLAY_HOLD;
        else if (tick && hold_last)
          state_nxt = (seq_last && !LOOP_EN) ? IDLE : PLAY_RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_nxt       = wr_ptr;
    rd_ptr_nxt       = rd_ptr;
    run_code_nxt     = run_code;
    run_dur_nxt      = run_dur;
    hold_cnt_nxt     = hold_cnt;
    length_nxt       = length;
    rec_full_nxt     = rec_full;
    current_note_nxt = current_note;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    mem_we_nxt       = 1'b0;
    wr_req           = 1'b0;
    case (state)
      IDLE: begin
        if (sw1) begin
          wr_ptr_nxt       = '0;
          length_nxt       = '0;
          rec_full_nxt     = 1'b0;
          run_code_nxt     = live_note;
          run_dur_nxt      = '0;
          current_note_nxt = live_note;
        end else if (play && length != '0) begin
          rd_ptr_nxt   = '0;
          mem_addr_nxt = '0;
        end
      end
      REC: begin
        current_note_nxt = live_note;
        // A tick in the same cycle as a code change or sw1 fall still belongs to the closing run.
        if (!sw1) begin
          wr_req           = (rec_dur != 8'd0);
          current_note_nxt = '0;
        end else if (live_note != run_code) begin
          wr_req       = (rec_dur != 8'd0);
          run_code_nxt = live_note;
          run_dur_nxt  = '0;
        end else if (tick) begin
          if (rec_dur == 8'hFF) begin
            wr_req      = 1'b1;
            run_dur_nxt = '0;
          end else begin
            run_dur_nxt = rec_dur;
          end
        end
        if (wr_req && !rec_full) begin
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = wr_ptr[ADDR_W-1:0];
          mem_wdata_nxt = {rec_dur, run_code};
          wr_ptr_nxt    = wr_ptr + ONE_LEN;
          if (wr_ptr == LAST_ADDR) rec_full_nxt = 1'b1;
        end
        if (!sw1) length_nxt = wr_ptr_nxt;
      end
      PLAY_RD, PLAY_LD, PLAY_HOLD: begin
        if (abort || play_stop) begin
          current_note_nxt = '0;
        end else if (state == PLAY_LD) begin
          current_note_nxt = rd_note;
          hold_cnt_nxt     = (rd_dur == 8'd0) ? 8'd1 : rd_dur;
        end else if (state == PLAY_HOLD && tick) begin
          hold_cnt_nxt = hold_cnt - 8'd1;
          if (hold_last) begin
            if (seq_last && !LOOP_EN) begin
              current_note_nxt = '0;
            end else begin
              rd_ptr_nxt   = seq_last ? '0 : rd_ptr + ADDR_W'(1);
              mem_addr_nxt = rd_ptr_nxt;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Self-checking bench for note_seq_ctrl: vector table for recording, scoreboard of expected
// memory writes, hand-written sequences for playback, abort, reset and the full-buffer case.
module tb_note_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0, sw1 = 1'b0, play = 1'b0;
  logic [4:0]  buttons = 5'd0;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  current_note;
  logic        busy, rec_full;
  logic [8:0]  length;

  logic        tick_s = 1'b0, sw1_s = 1'b0, play_s = 1'b0;
  logic [4:0]  buttons_s = 5'd0;
  logic [1:0]  mem_addr_s;
  logic        mem_we_s;
  logic [15:0] mem_wdata_s;
  logic [15:0] mem_rdata_s;
  logic [7:0]  current_note_s;
  logic        busy_s, rec_full_s;
  logic [2:0]  length_s;

  logic [15:0] mem [256];
  logic [15:0] mem_s [4];

  int checks = 0;
  int errors = 0;
  int wr_count_s = 0;
  int last_addr_s = -1;

  typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t got;

  typedef struct {
    logic [4:0]  btn;
    logic        sw;
    logic        tk;
    logic        wr;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic [7:0]  note;
    logic        bsy;
    logic [8:0]  len;
  } vec_t;
  vec_t vecs[10];

  note_seq_ctrl #(.ADDR_W(8), .NOTE_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .buttons(buttons), .sw1(sw1), .play(play),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .current_note(current_note), .busy(busy), .rec_full(rec_full), .length(length)
  );

  note_seq_ctrl #(.ADDR_W(2), .NOTE_W(8)) dut_small (
    .clk(clk), .reset(reset), .tick(tick_s), .buttons(buttons_s), .sw1(sw1_s), .play(play_s),
    .mem_addr(mem_addr_s), .mem_we(mem_we_s), .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s),
    .current_note(current_note_s), .busy(busy_s), .rec_full(rec_full_s), .length(length_s)
  );

  always #5 clk = ~clk;

  // Synchronous note memories: write on mem_we, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we_s) mem_s[mem_addr_s] <= mem_wdata_s;
    mem_rdata_s <= mem_s[mem_addr_s];
  end

  // Every write strobe must match the next expected entry of the scoreboard.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        got = exp_q.pop_front();
        if (mem_addr !== got.addr || mem_wdata !== got.data) begin
          errors++;
          $display("[TB] FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, got.addr, got.data);
        end
      end
    end
    if (reset && mem_we_s) begin
      wr_count_s++;
      last_addr_s = int'(mem_addr_s);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic s, input logic t, input logic p);
    buttons = b;
    sw1     = s;
    tick    = t;
    play    = p;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushWrite(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic runVectors(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) pushWrite(vecs[i].waddr, vecs[i].wdata);
      applyStimulus(vecs[i].btn, vecs[i].sw, vecs[i].tk, 1'b0);
      step();
      checkOutput($sformatf("%s_v%0d_note", tag, i), 32'(current_note), 32'(vecs[i].note));
      checkOutput($sformatf("%s_v%0d_busy", tag, i), 32'(busy), 32'(vecs[i].bsy));
      checkOutput($sformatf("%s_v%0d_length", tag, i), 32'(length), 32'(vecs[i].len));
    end
    step();
    checkOutput({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_rec_full"}, 32'(rec_full), 32'd0);
  endtask

  initial begin
    int chg_idx[3];
    int chg_val[3];
    int exp_idx[3];
    int exp_val[3];
    int nchg;
    int fall_idx;
    logic [7:0] prev_note;
    logic found;

    //         btn       sw    tk    wr    waddr  wdata      note  busy  len
    vecs[0] = '{5'b00000, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0, 1'b1, 9'd0};
    vecs[1] = '{5'b00001, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd1, 1'b1, 9'd0};
    vecs[2] = '{5'b00001, 1'b1, 1'b1, 1'b0, 8'd0, 16'h0000, 8'd1, 1'b1, 9'd0};
    vecs[3] = '{5'b00001, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd1, 1'b1, 9'd0};
    vecs[4] = '{5'b00001, 1'b1, 1'b1, 1'b0, 8'd0, 16'h0000, 8'd1, 1'b1, 9'd0};
    vecs[5] = '{5'b00001, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd1, 1'b1, 9'd0};
    vecs[6] = '{5'b00100, 1'b1, 1'b1, 1'b1, 8'd0, 16'h0301, 8'd3, 1'b1, 9'd0};
    vecs[7] = '{5'b00100, 1'b1, 1'b1, 1'b0, 8'd0, 16'h0000, 8'd3, 1'b1, 9'd0};
    vecs[8] = '{5'b00100, 1'b1, 1'b1, 1'b0, 8'd0, 16'h0000, 8'd3, 1'b1, 9'd0};
    vecs[9] = '{5'b00100, 1'b0, 1'b0, 1'b1, 8'd1, 16'h0203, 8'd0, 1'b0, 9'd2};

`ifdef LOOP_PLAY_EN
    exp_idx = '{3, 14, 22};
    exp_val = '{1, 3, 1};
`else
    exp_idx = '{3, 14, 20};
    exp_val = '{1, 3, 0};
`endif

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset_note", 32'(current_note), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rec_full", 32'(rec_full), 32'd0);
    checkOutput("reset_length", 32'(length), 32'd0);
    reset = 1'b1;
    step();

    $display("[TB] record b1 x3 ticks, b3 x2 ticks");
    runVectors("rec1");

    $display("[TB] playback with one tick per four clocks");
    nchg = 0;
    fall_idx = 0;
    prev_note = current_note;
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 30; n++) begin
      step();
      if (current_note != prev_note && nchg < 3) begin
        chg_idx[nchg] = n;
        chg_val[nchg] = int'(current_note);
        nchg++;
        prev_note = current_note;
      end
      if (!busy && fall_idx == 0) fall_idx = n;
      applyStimulus(5'd0, 1'b0, ((n + 1) % 4 == 0), 1'b0);
    end
    checkOutput("play_change_count", 32'(nchg), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("play_change%0d_cycle", k), 32'(chg_idx[k]), 32'(exp_idx[k]));
      checkOutput($sformatf("play_change%0d_note", k), 32'(chg_val[k]), 32'(exp_val[k]));
    end
`ifdef LOOP_PLAY_EN
    checkOutput("loop_still_busy", 32'(busy), 32'd1);
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("loop_stop_note", 32'(current_note), 32'd0);
    checkOutput("loop_stop_busy", 32'(busy), 32'd0);
`else
    checkOutput("play_busy_fall_cycle", 32'(fall_idx), 32'd20);
    checkOutput("play_end_busy", 32'(busy), 32'd0);
`endif
    step();

    $display("[TB] record b2 for 300 ticks, rest for 1 tick");
    applyStimulus(5'b00010, 1'b1, 1'b0, 1'b0);
    step();
    for (int t = 1; t <= 300; t++) begin
      if (t == 255) pushWrite(8'd0, 16'hFF02);
      applyStimulus(5'b00010, 1'b1, 1'b1, 1'b0);
      step();
    end
    pushWrite(8'd1, 16'h2D02);
    applyStimulus(5'd0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(5'd0, 1'b1, 1'b1, 1'b0);
    step();
    pushWrite(8'd2, 16'h0100);
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("sat_length", 32'(length), 32'd3);
    checkOutput("sat_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("sat_busy", 32'(busy), 32'd0);

    $display("[TB] reset in the middle of a recording");
    applyStimulus(5'b00001, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(5'b00001, 1'b1, 1'b1, 1'b0);
    step();
    pushWrite(8'd0, 16'h0101);
    applyStimulus(5'b00010, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(5'b00010, 1'b1, 1'b1, 1'b0);
    step();
    pushWrite(8'd1, 16'h0102);
    applyStimulus(5'b00100, 1'b1, 1'b0, 1'b0);
    step();
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("midrst_note", 32'(current_note), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rec_full", 32'(rec_full), 32'd0);
    checkOutput("midrst_length", 32'(length), 32'd0);
    checkOutput("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    $display("[TB] re-record, then raise sw1 during the second note");
    runVectors("rec2");
    found = 1'b0;
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 30 && !found; n++) begin
      step();
      if (current_note == 8'd3) found = 1'b1;
      else applyStimulus(5'd0, 1'b0, ((n + 1) % 4 == 0), 1'b0);
    end
    checkOutput("abort_reached_note3", 32'(found), 32'd1);
    applyStimulus(5'd0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("abort_note", 32'(current_note), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    step();
    checkOutput("abort_then_rec_busy", 32'(busy), 32'd1);
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("empty_rec_length", 32'(length), 32'd0);

    $display("[TB] play with nothing recorded");
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("play_len0_busy", 32'(busy), 32'd0);
    step();
    checkOutput("play_len0_busy_later", 32'(busy), 32'd0);

    $display("[TB] small buffer: alternate b1/b2 every tick");
    sw1_s = 1'b1;
    buttons_s = 5'b00001;
    step();
    for (int k = 0; k < 6; k++) begin
      tick_s = 1'b1;
      step();
      tick_s = 1'b0;
      buttons_s = (k % 2 == 0) ? 5'b00010 : 5'b00001;
      step();
    end
    tick_s = 1'b1;
    step();
    tick_s = 1'b0;
    sw1_s = 1'b0;
    step();
    step();
    checkOutput("small_write_count", 32'(wr_count_s), 32'd4);
    checkOutput("small_last_addr", 32'(last_addr_s), 32'd3);
    checkOutput("small_rec_full", 32'(rec_full_s), 32'd1);
    checkOutput("small_length", 32'(length_s), 32'd4);
    checkOutput("small_mem2", 32'(mem_s[2]), 32'h0101);
    checkOutput("small_mem3", 32'(mem_s[3]), 32'h0102);
    checkOutput("small_busy", 32'(busy_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/note_seq_ctrl.md
# note_seq_ctrl

Record/playback sequencer for the note memory of the button-piano design. In record mode it converts the five note buttons into run-length entries {duration, note} and writes them sequentially into the synchronous note memory. In playback mode it reads the entries back in order and drives `current_note` for each stored duration. It owns the memory address, write enable and write data, replacing hand-wired address muxing and increment logic around the memory.

## Interface
Parameters:
- ADDR_W, 8, memory address width; capacity DEPTH = 2^ADDR_W entries
- NOTE_W, 8, width of `current_note` and of the note field in a memory word

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle duration time-base strobe; 1 duration unit = 1 tick
- buttons  in  5  {b5,b4,b3,b2,b1}, debounced levels
- sw1  in  1  record switch (level)
- play  in  1  one-cycle playback command pulse
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  one-cycle write strobe
- mem_wdata  out  8+NOTE_W  {dur[7:0], note[NOTE_W-1:0]}
- mem_rdata  in  8+NOTE_W  read data, valid 1 cycle after `mem_addr` is presented
- current_note  out  NOTE_W  note code being sounded (0 = rest)
- busy  out  1  high in any state other than IDLE
- rec_full  out  1  record buffer full
- length  out  ADDR_W+1  entries stored by the last recording

## Operation
- Note code: lowest-index pressed button wins (b1→1 … b5→5); no button pressed → 0 (rest). The code is zero-extended to NOTE_W.
- States: IDLE, REC, PLAY_RD, PLAY_LD, PLAY_HOLD.
- IDLE:
  - `sw1`=1 → REC. On entry: wr_ptr=0, length=0, rec_full=0, run_code=current code, run_dur=0.
  - `play`=1 with `sw1`=0 and length≠0 → PLAY_RD with rd_ptr=0.
  - `play` with length=0 is ignored.
- REC:
  - `current_note` follows the live code (registered).
  - Each `tick` increments run_dur.
  - Code differs from run_code and run_dur≠0 → write {run_dur, run_code} at wr_ptr, wr_ptr++, then start a new run with run_dur=0.
  - Code change with run_dur=0: the run is discarded and the new code is taken with no write.
  - run_dur reaching 255 on a tick → write {255, run_code} and continue the same code with run_dur=0.
  - After the write to address DEPTH-1: rec_full=1 and all further writes are suppressed.
  - `sw1` falling → flush the current run if run_dur≠0 and not full, set length=wr_ptr, then → IDLE.
- PLAY_RD: present rd_ptr on `mem_addr` → PLAY_LD.
- PLAY_LD: load `current_note` = rdata note field and hold_cnt = dur field → PLAY_HOLD.
- PLAY_HOLD:
  - Each `tick` decrements hold_cnt.
  - On the tick where hold_cnt goes from 1 to 0:
    - rd_ptr = length-1 → end of sequence.
    - Otherwise rd_ptr++ → PLAY_RD.
  - A stored duration of 0 is treated as 1.
  - End of sequence: `current_note`=0 → IDLE.
- `sw1` rising during any PLAY state → abort: `current_note`=0 → IDLE. REC is entered on the following cycle.
- `buttons` are ignored outside REC. `play` is ignored in REC.

## Timing
- Reset values: state IDLE, mem_addr=0, mem_we=0, mem_wdata=0, current_note=0, busy=0, rec_full=0, length=0, all pointers and counters 0.
- All outputs are registered.
- Writes:
  - `mem_we` is high for exactly one cycle, with `mem_addr`/`mem_wdata` stable in that cycle.
  - The write occurs the cycle after the clock edge that samples the code change, saturation tick or `sw1` fall.
- Playback:
  - First `current_note` appears 2 cycles after the `play` pulse (PLAY_RD, PLAY_LD).
  - Gap between consecutive notes is 2 cycles (PLAY_RD, PLAY_LD) plus the stored ticks.
- Simultaneous events:
  - Tick and code change in the same cycle: the tick counts toward the old run, then the write happens.
  - `sw1` fall and code change in the same cycle: only the old run is flushed.
- Pointers never wrap in record; write address range is 0..DEPTH-1.

## Configuration
- LOOP_PLAY_EN defined:
  - At end of sequence, rd_ptr wraps to 0 and playback continues (PLAY_RD).
  - A `play` pulse during PLAY states stops playback: `current_note`=0 → IDLE.
- LOOP_PLAY_EN undefined:
  - Playback is one-shot.
  - `play` during PLAY states is ignored.

## Test plan
- Reset mid-recording (after 2 writes) → all outputs return to reset values immediately, and length=0.
- REC: b1 held for 3 ticks, then b3 held for 2 ticks, then `sw1` low → writes {3,1}@0 and {2,3}@1; length=2; no other `mem_we`.
- REC: b2 held for 300 ticks, then release for 1 tick, then `sw1` low → writes {255,2}@0, {45,2}@1, {1,0}@2.
- Play after the b1/b3 recording, 1 tick per 4 clk → `current_note`=1 for 3 ticks then 3 for 2 ticks, then 0; `busy` falls; `mem_we` never asserted.
- ADDR_W=2 with alternating b1/b2 each tick for 6 changes → 4 writes, rec_full=1 after the write at address 3, length=4.
- `sw1` raised during the 2nd note of playback → `current_note`=0 and state IDLE next cycle, then REC. With LOOP_PLAY_EN, the 2-entry sequence repeats at address 0 until a `play` pulse stops it.
